matrix_store_param: RTL and testbench

Parametrised matrix store for the matrix calculator, the next generation of the fixed 10-slot / 5x5 / 8-bit store. It holds up to SLOTS matrices of up to MAX_DIM x MAX_DIM signed elements. Matrices are written and read as streams with valid/ready handshakes. Slot allocation honours a runtime per-size limit and evicts the oldest matrix, using a wrap-safe sequence stamp. It sits between the input parser / ALU result path (write side) and the display/operand fetch logic (read side).

---
 rtl/matrix_store_param.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_matrix_store_param.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_store_param.sv
// -----------------------------------------------------------------------------
// matrix_store_param
//
// Parametrised matrix store. Holds up to SLOTS matrices of up to
// MAX_DIM x MAX_DIM signed elements. Matrices are written and read as
// row-major element streams.
//
// Handshake rule (write and read streams): a beat transfers on a rising clk
// edge where both valid and ready are high. A producer holding valid high with
// ready low keeps its data/last stable until the transfer happens.
//
// Slot allocation honours a runtime per-size limit (max_per_size, 0 means
// unlimited). When a slot must be reused, the victim is the oldest matrix,
// measured with a modular sequence stamp so the order survives counter wrap.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   elem_min, elem_max         inclusive signed legal element range
//   max_per_size               max live matrices per (m,n), 0 = unlimited
//   wr_start, wr_m, wr_n       begin a write session (taken in IDLE only)
//   wr_valid/wr_ready/wr_data/wr_last   write element stream
//   rd_start, rd_id            begin reading slot rd_id (taken in IDLE only)
//   rd_valid/rd_ready/rd_data/rd_last   read element stream
//   rd_m, rd_n                 dims of slot under read, latched at rd_start
//   del_req, del_id            invalidate a slot (taken in IDLE only)
//   busy                       FSM is not IDLE
//   done, done_id              one-cycle pulse on write commit + slot id
//   err, err_code              one-cycle pulse; 1 bad dims, 2 element out of
//                              range, 3 bad/empty read or delete id
//   slot_valid_flat, slot_m_flat, slot_n_flat   live slot metadata
//   state_dbg                  current FSM state encoding
// -----------------------------------------------------------------------------
module matrix_store_param #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int SLOTS   = 10,
  parameter int SEQ_W   = 8,
  localparam int DIM_W  = $clog2(MAX_DIM + 1),
  localparam int ID_W   = $clog2(SLOTS),
  localparam int CNT_W  = $clog2(SLOTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [DATA_W-1:0]    elem_min,
  input  logic signed [DATA_W-1:0]    elem_max,
  input  logic [CNT_W-1:0]            max_per_size,
  input  logic                        wr_start,
  input  logic [DIM_W-1:0]            wr_m,
  input  logic [DIM_W-1:0]            wr_n,
  input  logic                        wr_valid,
  input  logic signed [DATA_W-1:0]    wr_data,
  input  logic                        wr_last,
  output logic                        wr_ready,
  input  logic                        rd_start,
  input  logic [ID_W-1:0]             rd_id,
  output logic                        rd_valid,
  output logic signed [DATA_W-1:0]    rd_data,
  output logic                        rd_last,
  input  logic                        rd_ready,
  output logic [DIM_W-1:0]            rd_m,
  output logic [DIM_W-1:0]            rd_n,
  input  logic                        del_req,
  input  logic [ID_W-1:0]             del_id,
  output logic                        busy,
  output logic                        done,
  output logic [ID_W-1:0]             done_id,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [SLOTS-1:0]            slot_valid_flat,
  output logic [SLOTS*DIM_W-1:0]      slot_m_flat,
  output logic [SLOTS*DIM_W-1:0]      slot_n_flat,
  output logic [2:0]                  state_dbg
);

  localparam int ELEMS  = MAX_DIM * MAX_DIM;
  localparam int TOT_W  = $clog2(ELEMS + 1);
  localparam int ADDR_W = $clog2(SLOTS * ELEMS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALLOC = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [2:0]               state;
  logic [SLOTS-1:0]         slot_valid;
  logic [DIM_W-1:0]         slot_m     [SLOTS];
  logic [DIM_W-1:0]         slot_n     [SLOTS];
  logic [SEQ_W-1:0]         slot_stamp [SLOTS];
  logic [SEQ_W-1:0]         seq;

  logic [ID_W-1:0]          cur_slot;
  logic [DIM_W-1:0]         cur_m, cur_n;
  logic [TOT_W-1:0]         total, idx;
  logic [ID_W-1:0]          rd_slot;
  logic [TOT_W-1:0]         rd_total, ridx;

  logic signed [DATA_W-1:0] mem [SLOTS*ELEMS];

  // True when id names an existing, valid slot. Written as a scan so an id
  // beyond SLOTS-1 never indexes past the slot table.
  function automatic logic id_live(input logic [ID_W-1:0] id,
                                   input logic [SLOTS-1:0] v);
    logic live;
    live = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (id == ID_W'(k)) live = v[k];
    end
    return live;
  endfunction

  // ---------------------------------------------------------------------------
  // Victim selection, evaluated while in ALLOC. Ages are seq - stamp modulo
  // 2^SEQ_W; strict '>' on an upward scan makes age ties go to the lowest index.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] same_cnt;
  logic             free_found, all_found, same_found;
  logic [ID_W-1:0]  free_id, all_id, same_id, victim;
  logic [SEQ_W-1:0] all_age, same_age, age_k;

  always_comb begin
    same_cnt   = '0;
    free_found = 1'b0;
    all_found  = 1'b0;
    same_found = 1'b0;
    free_id    = '0;
    all_id     = '0;
    same_id    = '0;
    all_age    = '0;
    same_age   = '0;
    age_k      = '0;
    for (int k = 0; k < SLOTS; k++) begin
      age_k = seq - slot_stamp[k];
      if (!slot_valid[k]) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_id    = ID_W'(k);
        end
      end else begin
        if (!all_found || age_k > all_age) begin
          all_found = 1'b1;
          all_age   = age_k;
          all_id    = ID_W'(k);
        end
        if (slot_m[k] == cur_m && slot_n[k] == cur_n) begin
          same_cnt = same_cnt + CNT_W'(1);
          if (!same_found || age_k > same_age) begin
            same_found = 1'b1;
            same_age   = age_k;
            same_id    = ID_W'(k);
          end
        end
      end
    end
    // The overall-oldest scan only sees valid slots, which is every slot
    // whenever no free slot exists.
    if (max_per_size != '0 && same_cnt >= max_per_size) victim = same_id;
    else if (free_found)                                 victim = free_id;
    else                                                 victim = all_id;
  end

  // ---------------------------------------------------------------------------
  // Element array write port and commit detection
  // ---------------------------------------------------------------------------
  logic                     in_range, mem_we, commit;
  logic signed [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0]        wr_addr, rd_addr;

  assign in_range = !(wr_data < elem_min) && !(wr_data > elem_max);
  assign wr_addr  = ADDR_W'(cur_slot) * ADDR_W'(ELEMS) + ADDR_W'(idx);
  assign rd_addr  = ADDR_W'(rd_slot)  * ADDR_W'(ELEMS) + ADDR_W'(ridx);

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    commit    = 1'b0;
    if (state == S_WRITE && wr_valid && in_range) begin
      mem_we = 1'b1;
      commit = (idx == total - TOT_W'(1));
    end else if (state == S_PAD) begin
      mem_we    = 1'b1;
      mem_wdata = '0;
      commit    = (idx == total - TOT_W'(1));
    end
  end

  // Array contents are don't-care after reset, so the array has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Control FSM, metadata and read output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      slot_valid <= '0;
      seq        <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        slot_m[k]     <= '0;
        slot_n[k]     <= '0;
        slot_stamp[k] <= '0;
      end
      cur_slot <= '0;
      cur_m    <= '0;
      cur_n    <= '0;
      total    <= '0;
      idx      <= '0;
      rd_slot  <= '0;
      rd_total <= '0;
      ridx     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_m     <= '0;
      rd_n     <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // One request per cycle: del_req > wr_start > rd_start.
          if (del_req) begin
            if (id_live(del_id, slot_valid)) begin
              slot_valid[del_id] <= 1'b0;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd3;
            end
          end else if (wr_start) begin
            if (wr_m == '0 || wr_n == '0 ||
                wr_m > DIM_W'(MAX_DIM) || wr_n > DIM_W'(MAX_DIM)) begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end else begin
              cur_m <= wr_m;
              cur_n <= wr_n;
              total <= TOT_W'(wr_m) * TOT_W'(wr_n);
              state <= S_ALLOC;
            end
          end else if (rd_start) begin
            if (id_live(rd_id, slot_valid)) begin
              rd_slot  <= rd_id;
              rd_m     <= slot_m[rd_id];
              rd_n     <= slot_n[rd_id];
              rd_total <= TOT_W'(slot_m[rd_id]) * TOT_W'(slot_n[rd_id]);
              ridx     <= '0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= S_READ;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd3;
            end
          end
        end

        S_ALLOC: begin
          cur_slot           <= victim;
          slot_valid[victim] <= 1'b0;
          idx                <= '0;
          state              <= S_WRITE;
        end

        S_WRITE: begin
          if (wr_valid) begin
            if (!in_range) begin
              // Abandoned write: the slot was already invalidated in ALLOC.
              err      <= 1'b1;
              err_code <= 2'd2;
              state    <= S_IDLE;
            end else begin
              idx <= idx + TOT_W'(1);
              if (!commit && wr_last) state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          idx <= idx + TOT_W'(1);
        end

        S_READ: begin
          if (rd_valid && rd_ready && rd_last) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            state    <= S_IDLE;
          end else if (!rd_valid || rd_ready) begin
            rd_data  <= mem[rd_addr];
            rd_last  <= (ridx == rd_total - TOT_W'(1));
            rd_valid <= 1'b1;
            ridx     <= ridx + TOT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase

      // Commit takes the pre-increment seq as the slot's stamp.
      if (commit) begin
        slot_valid[cur_slot] <= 1'b1;
        slot_m[cur_slot]     <= cur_m;
        slot_n[cur_slot]     <= cur_n;
        slot_stamp[cur_slot] <= seq;
        seq                  <= seq + SEQ_W'(1);
        done                 <= 1'b1;
        done_id              <= cur_slot;
        state                <= S_IDLE;
      end
    end
  end

  assign wr_ready  = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_comb begin
    slot_valid_flat = slot_valid;
    slot_m_flat     = '0;
    slot_n_flat     = '0;
    for (int k = 0; k < SLOTS; k++) begin
      slot_m_flat[k*DIM_W +: DIM_W] = slot_m[k];
      slot_n_flat[k*DIM_W +: DIM_W] = slot_n[k];
    end
  end

endmodule

// File: tb/tb_matrix_store_param.sv
// -----------------------------------------------------------------------------
// tb_matrix_store_param
//
// Bench for matrix_store_param. A behavioural model (slot table with plain
// integer arrays and modular ages) predicts done ids, error codes and read
// beats; predictions go into queues, and a negedge monitor pops and compares
// whenever the store presents a read beat, a done pulse or an err pulse.
// -----------------------------------------------------------------------------
module tb_matrix_store_param;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int SLOTS   = 10;
  localparam int SEQ_W   = 8;
  localparam int DIM_W   = 3;
  localparam int ID_W    = 4;
  localparam int CNT_W   = 4;
  localparam int ELEMS   = MAX_DIM * MAX_DIM;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]       elem_min, elem_max;
  logic [CNT_W-1:0]        max_per_size;
  logic                    wr_start, wr_valid, wr_last, wr_ready;
  logic [DIM_W-1:0]        wr_m, wr_n;
  logic [DATA_W-1:0]       wr_data;
  logic                    rd_start, rd_valid, rd_last, rd_ready;
  logic [ID_W-1:0]         rd_id, del_id, done_id;
  logic [DATA_W-1:0]       rd_data;
  logic [DIM_W-1:0]        rd_m, rd_n;
  logic                    del_req, busy, done, err;
  logic [1:0]              err_code;
  logic [SLOTS-1:0]        slot_valid_flat;
  logic [SLOTS*DIM_W-1:0]  slot_m_flat, slot_n_flat;
  logic [2:0]              state_dbg;

  matrix_store_param #(
    .DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .SLOTS(SLOTS), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .elem_min(elem_min), .elem_max(elem_max), .max_per_size(max_per_size),
    .wr_start(wr_start), .wr_m(wr_m), .wr_n(wr_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_id(rd_id),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .rd_m(rd_m), .rd_n(rd_n),
    .del_req(del_req), .del_id(del_id),
    .busy(busy), .done(done), .done_id(done_id), .err(err), .err_code(err_code),
    .slot_valid_flat(slot_valid_flat), .slot_m_flat(slot_m_flat),
    .slot_n_flat(slot_n_flat), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q[$];   // {last, data} per expected read beat
  int done_q[$];               // expected done_id per commit
  int err_q[$];                // expected err_code per error pulse

  // ---------------- reference model ----------------
  bit mv[SLOTS];
  int mm[SLOTS], mn[SLOTS], mstamp[SLOTS];
  int md[SLOTS][ELEMS];
  int mseq;
  int mmax;
  int wvals[ELEMS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic bit model_live(input int id);
    if (id < 0 || id >= SLOTS) return 1'b0;
    return mv[id];
  endfunction

  // Slot choice from the allocation rules: per-size limit evicts the oldest
  // same-size matrix, else lowest free slot, else oldest overall.
  function automatic int model_pick(input int m, input int n);
    int same, fr, os, oa, os_age, oa_age, age;
    same = 0; fr = -1; os = -1; oa = -1; os_age = -1; oa_age = -1;
    for (int k = 0; k < SLOTS; k++) begin
      if (!mv[k]) begin
        if (fr < 0) fr = k;
      end else begin
        age = ((mseq - mstamp[k]) % 256 + 256) % 256;
        if (age > oa_age) begin oa_age = age; oa = k; end
        if (mm[k] == m && mn[k] == n) begin
          same++;
          if (age > os_age) begin os_age = age; os = k; end
        end
      end
    end
    if (mmax != 0 && same >= mmax) return os;
    if (fr >= 0) return fr;
    return oa;
  endfunction

  // ---------------- monitor ----------------
  logic            pv, pr;
  logic [DATA_W:0] pbeat;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_beat", {rd_last, rd_data}, pbeat);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) fail_now("rd_unexpected_beat");
        else check("rd_beat", {rd_last, rd_data}, exp_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else check("done_id", done_id, done_q.pop_front());
      end
      if (err) begin
        if (err_q.size() == 0) fail_now("unexpected_err");
        else check("err_code", err_code, err_q.pop_front());
      end
      pv    = rd_valid;
      pr    = rd_ready;
      pbeat = {rd_last, rd_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin tick(); t++; end
    if (busy) fail_now(name);
  endtask

  task automatic clear_inputs();
    wr_start = 0; wr_m = '0; wr_n = '0; wr_valid = 0; wr_data = '0; wr_last = 0;
    rd_start = 0; rd_id = '0; rd_ready = 0; del_req = 0; del_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int k = 0; k < SLOTS; k++) begin
      mv[k] = 0; mm[k] = 0; mn[k] = 0; mstamp[k] = 0;
    end
    mseq = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_out", {rd_valid, rd_last, rd_data, rd_m, rd_n}, 0);
    check("rst_pulses", {done, done_id, err, err_code}, 0);
    check("rst_slot_valid", slot_valid_flat, 0);
    check("rst_slot_dims", {slot_m_flat, slot_n_flat}, 0);
    check("rst_state", state_dbg, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_meta(input string tag);
    logic [SLOTS-1:0]       ev;
    logic [SLOTS*DIM_W-1:0] em, en;
    for (int k = 0; k < SLOTS; k++) begin
      ev[k] = mv[k];
      em[k*DIM_W +: DIM_W] = DIM_W'(mm[k]);
      en[k*DIM_W +: DIM_W] = DIM_W'(mn[k]);
    end
    check({tag, "_slot_valid"}, slot_valid_flat, ev);
    check({tag, "_slot_m"}, slot_m_flat, em);
    check({tag, "_slot_n"}, slot_n_flat, en);
  endtask

  // Writes an m x n matrix from wvals[0..supply-1]; bad_at >= 0 sends
  // wvals[bad_at] as an out-of-range element and stops there.
  task automatic write_mat(input int m, input int n, input int supply, input int bad_at,
                           input bit full, input bit chk);
    int tot, slot, send, t;
    tot = m * n;
    wr_m = DIM_W'(m);
    wr_n = DIM_W'(n);
    wr_start = 1;
    if (m < 1 || m > MAX_DIM || n < 1 || n > MAX_DIM) begin
      err_q.push_back(1);
      tick();
      wr_start = 0;
      tick();
      return;
    end
    slot = model_pick(m, n);
    mv[slot] = 0;
    if (bad_at >= 0) begin
      err_q.push_back(2);
    end else begin
      done_q.push_back(slot);
      for (int i = 0; i < tot; i++) md[slot][i] = (i < supply) ? wvals[i] : 0;
      mm[slot] = m; mn[slot] = n; mstamp[slot] = mseq;
      mseq = (mseq + 1) % 256;
      mv[slot] = 1;
    end
    tick();
    wr_start = 0;
    if (chk) begin
      check("alloc_busy", busy, 1);
      check("alloc_wr_ready", wr_ready, 0);
    end
    send = (bad_at >= 0) ? bad_at + 1 : supply;
    for (int i = 0; i < send; i++) begin
      if (!full && $urandom_range(0, 2) == 0) begin wr_valid = 0; tick(); end
      wr_valid = 1;
      wr_data  = DATA_W'(wvals[i]);
      wr_last  = (i == supply - 1);
      t = 0;
      @(negedge clk);
      while (!wr_ready && t < 40) begin @(negedge clk); t++; end
      if (!wr_ready) begin fail_now("wr_ready_timeout"); break; end
      tick();
    end
    wr_valid = 0;
    wr_last  = 0;
    wait_idle("write_idle_timeout", 60);
  endtask

  // mode 0: rd_ready always high, 1: toggling, 2: random
  task automatic read_mat(input int id, input int mode);
    logic [DATA_W:0] beat;
    int tot;
    rd_id = ID_W'(id);
    rd_start = 1;
    if (!model_live(id)) begin
      err_q.push_back(3);
      tick();
      rd_start = 0;
      tick();
      return;
    end
    tot = mm[id] * mn[id];
    for (int i = 0; i < tot; i++) begin
      beat = {(i == tot - 1), DATA_W'(md[id][i])};
      exp_q.push_back(beat);
    end
    rd_ready = (mode == 0);
    tick();
    rd_start = 0;
    check("rd_m", rd_m, mm[id]);
    check("rd_n", rd_n, mn[id]);
    for (int c = 0; c < 400; c++) begin
      case (mode)
        0:       rd_ready = 1;
        1:       rd_ready = c[0];
        default: rd_ready = $urandom_range(0, 1);
      endcase
      tick();
      if (!busy) break;
    end
    if (busy) fail_now("read_timeout");
    rd_ready = 0;
  endtask

  task automatic del_slot(input int id);
    del_id  = ID_W'(id);
    del_req = 1;
    if (model_live(id)) mv[id] = 0;
    else err_q.push_back(3);
    tick();
    del_req = 0;
    tick();
  endtask

  task automatic rand_vals(input int lo, input int hi);
    for (int i = 0; i < ELEMS; i++) wvals[i] = int'($urandom_range(hi - lo)) + lo;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int p, m, n, tot, sup, bad, op;
    clear_inputs();
    elem_min = DATA_W'(-100);
    elem_max = DATA_W'(100);
    mmax = 0;
    max_per_size = '0;
    do_reset();

    // 2x3 {1..6}, full rate, then full-rate read of slot 0
    for (int i = 0; i < 6; i++) wvals[i] = i + 1;
    write_mat(2, 3, 6, -1, 1, 1);
    read_mat(0, 0);
    check("busy_after_read", busy, 0);
    check_meta("t1");

    // 3x3 with only 4 elements supplied: remainder padded with zero
    for (int i = 0; i < 4; i++) wvals[i] = i + 1;
    write_mat(3, 3, 4, -1, 1, 0);
    read_mat(1, 1);
    check_meta("t2");

    // Per-size limit of 2: the third 2x2 replaces the oldest 2x2 (slot 0)
    do_reset();
    mmax = 2;
    max_per_size = CNT_W'(2);
    for (int j = 0; j < 3; j++) begin
      rand_vals(-100, 100);
      write_mat(2, 2, 4, -1, 0, 0);
    end
    check_meta("t3");
    read_mat(0, 2);

    // Fill every slot, delete 4, refill 4, then evict the oldest (slot 0)
    do_reset();
    mmax = 0;
    max_per_size = '0;
    for (int j = 0; j < SLOTS; j++) begin
      rand_vals(-100, 100);
      m = $urandom_range(1, MAX_DIM);
      n = $urandom_range(1, MAX_DIM);
      write_mat(m, n, m * n, -1, 1, 0);
    end
    del_slot(4);
    rand_vals(-100, 100);
    write_mat(2, 2, 4, -1, 1, 0);
    rand_vals(-100, 100);
    write_mat(3, 1, 3, -1, 0, 0);
    check_meta("t4");
    read_mat(4, 0);
    read_mat(0, 2);

    // Error cases
    elem_min = DATA_W'(-8);
    elem_max = DATA_W'(7);
    rand_vals(-8, 7);
    wvals[2] = 9;
    write_mat(2, 2, 4, 2, 1, 0);
    write_mat(0, 3, 1, -1, 1, 0);
    write_mat(2, 6, 1, -1, 1, 0);
    p = 0;
    for (int k = SLOTS - 1; k >= 0; k--) if (!mv[k]) p = k;
    read_mat(p, 0);
    read_mat(12, 0);
    del_slot(11);
    check_meta("t5");

    // Simultaneous requests: delete wins, write and read are dropped
    p = 0;
    for (int k = SLOTS - 1; k >= 0; k--) if (mv[k]) p = k;
    del_req = 1; del_id = ID_W'(p);
    wr_start = 1; wr_m = 3'd2; wr_n = 3'd2;
    rd_start = 1; rd_id = ID_W'(p);
    mv[p] = 0;
    tick();
    clear_inputs();
    tick();
    check("priority_busy", busy, 0);
    check_meta("prio");

    // Randomised mix of operations
    elem_min = DATA_W'(-100);
    elem_max = DATA_W'(100);
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        m = $urandom_range(1, MAX_DIM);
        n = $urandom_range(1, MAX_DIM);
        tot = m * n;
        sup = $urandom_range(1, tot);
        rand_vals(-100, 100);
        bad = -1;
        if (op == 4 && $urandom_range(0, 3) == 0) begin
          bad = $urandom_range(0, sup - 1);
          wvals[bad] = ($urandom_range(0, 1) == 1) ? 101 : -101;
        end
        write_mat(m, n, sup, bad, bit'($urandom_range(0, 1)), 0);
      end else if (op <= 7) begin
        read_mat($urandom_range(0, 11), $urandom_range(0, 2));
      end else if (op == 8) begin
        del_slot($urandom_range(0, 11));
      end else begin
        mmax = $urandom_range(0, 3);
        max_per_size = CNT_W'(mmax);
        if ($urandom_range(0, 1) == 1)
          write_mat(($urandom_range(0, 1) == 1) ? 0 : 6, $urandom_range(1, 5), 1, -1, 1, 0);
      end
      check_meta("rand");
    end

    // Reset in the middle of a stalled read
    mmax = 0;
    max_per_size = '0;
    rand_vals(-100, 100);
    write_mat(5, 5, 25, -1, 1, 0);
    p = 0;
    for (int k = SLOTS - 1; k >= 0; k--) if (mv[k]) p = k;
    rd_id = ID_W'(p);
    rd_start = 1;
    rd_ready = 0;
    tick();
    rd_start = 0;
    tick();
    check("stall_rd_valid", rd_valid, 1);
    tick();
    do_reset();
    check_meta("t7");

    repeat (3) tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
